// File: rtl/ring_pattern_decoder_if.sv
// ring_pattern_decoder_if
//   Groups the sample stream and the decoder status for ring_pattern_decoder.
//   Signals:
//     in_valid    - in_pat carries a sample this cycle (source -> decoder)
//     in_pat      - sampled ring pattern, WIDTH bits (source -> decoder)
//     clr_err     - synchronous clear of err_cnt (source -> decoder)
//     locked      - decoder is locked to the rotation sequence
//     phase       - phase index of the last accepted sample
//     phase_valid - phase is meaningful
//     err         - one-cycle pulse on a sequence error while locked
//     err_cnt     - saturating error count
//     state_dbg   - current FSM state (HUNT=0, CONFIRM=1, LOCKED=2)
//   Handshake: a sample is consumed on every rising clk edge where in_valid
//   is 1; there is no back-pressure, the decoder is always ready.
//   Modports: master = pattern source / bench, slave = decoder.
interface ring_pattern_decoder_if #(
    parameter int WIDTH   = 4,
    parameter int PHASE_W = 2,
    parameter int ERR_W   = 8
);
    logic               in_valid;
    logic [WIDTH-1:0]   in_pat;
    logic               clr_err;
    logic               locked;
    logic [PHASE_W-1:0] phase;
    logic               phase_valid;
    logic               err;
    logic [ERR_W-1:0]   err_cnt;
    logic [1:0]         state_dbg;

    modport master (
        output in_valid, in_pat, clr_err,
        input  locked, phase, phase_valid, err, err_cnt, state_dbg
    );

    modport slave (
        input  in_valid, in_pat, clr_err,
        output locked, phase, phase_valid, err, err_cnt, state_dbg
    );
endinterface

// File: rtl/ring_pattern_decoder.sv
// ring_pattern_decoder
//   Receive side of a rotating ring-counter pattern. Each valid sample is
//   looked up against every rotation of SEED, the decoder locks after
//   LOCK_COUNT consecutive correct steps, reports the phase index, and
//   flags / counts sequence errors seen while locked.
//   Ports:
//     clk - rising-edge clock
//     rst - synchronous, active-high reset
//     bus - ring_pattern_decoder_if.slave (sample in, status out)
//   All outputs are registered; they update on the edge that samples
//   in_valid=1 (latency 1). clr_err acts on any edge.
module ring_pattern_decoder #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] SEED       = 4'b1001,
    parameter int               PHASE_W    = 2,
    parameter int               LOCK_COUNT = 3,
    parameter int               ERR_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    ring_pattern_decoder_if.slave bus
);

    localparam logic [1:0] HUNT    = 2'd0;
    localparam logic [1:0] CONFIRM = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    logic [1:0]         state;
    logic [WIDTH-1:0]   last_pat;
    logic [3:0]         match_cnt;
    logic               locked_q;
    logic [PHASE_W-1:0] phase_q;
    logic               phase_valid_q;
    logic               err_q;
    logic [ERR_W-1:0]   err_cnt_q;

    logic               hit;
    logic [PHASE_W-1:0] hit_idx;
    logic [WIDTH-1:0]   exp_pat;
    logic               is_exp;
    logic               err_event;

    function automatic logic [WIDTH-1:0] rotr1(input logic [WIDTH-1:0] v);
        return {v[0], v[WIDTH-1:1]};
    endfunction

    // Parallel compare against all WIDTH rotations of SEED. Rotations are
    // distinct for a legal SEED, so at most one compare hits.
    always_comb begin
        logic [WIDTH-1:0] r;
        hit     = 1'b0;
        hit_idx = '0;
        r       = SEED;
        for (int k = 0; k < WIDTH; k++) begin
            if (bus.in_pat == r) begin
                hit     = 1'b1;
                hit_idx = PHASE_W'(k);
            end
            r = rotr1(r);
        end
    end

    assign exp_pat   = rotr1(last_pat);
    assign is_exp    = (bus.in_pat == exp_pat);
    assign err_event = bus.in_valid && (state == LOCKED) && !is_exp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HUNT;
            last_pat      <= SEED;
            match_cnt     <= '0;
            locked_q      <= 1'b0;
            phase_q       <= '0;
            phase_valid_q <= 1'b0;
            err_q         <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            err_q <= err_event;

            if (bus.in_valid) begin
                case (state)
                    HUNT: begin
                        if (hit) begin
                            state         <= CONFIRM;
                            last_pat      <= bus.in_pat;
                            phase_q       <= hit_idx;
                            match_cnt     <= 4'd1;
                            phase_valid_q <= 1'b1;
                        end else begin
                            phase_valid_q <= 1'b0;
                        end
                    end

                    CONFIRM: begin
                        if (is_exp) begin
                            // exp is always a rotation, so hit_idx is the
                            // next phase modulo WIDTH.
                            last_pat  <= bus.in_pat;
                            phase_q   <= hit_idx;
                            match_cnt <= match_cnt + 4'd1;
                            if (match_cnt + 4'd1 == 4'(LOCK_COUNT)) begin
                                locked_q <= 1'b1;
                                state    <= LOCKED;
                            end
                        end else if (hit) begin
                            last_pat  <= bus.in_pat;
                            phase_q   <= hit_idx;
                            match_cnt <= 4'd1;
                        end else begin
                            state         <= HUNT;
                            match_cnt     <= '0;
                            phase_valid_q <= 1'b0;
                        end
                    end

                    LOCKED: begin
                        if (is_exp) begin
                            last_pat <= bus.in_pat;
                            phase_q  <= hit_idx;
                        end else begin
                            locked_q <= 1'b0;
                            if (hit) begin
                                state         <= CONFIRM;
                                last_pat      <= bus.in_pat;
                                phase_q       <= hit_idx;
                                match_cnt     <= 4'd1;
                                phase_valid_q <= 1'b1;
                            end else begin
                                state         <= HUNT;
                                match_cnt     <= '0;
                                phase_valid_q <= 1'b0;
                            end
                        end
                    end

                    default: begin
                        state         <= HUNT;
                        match_cnt     <= '0;
                        locked_q      <= 1'b0;
                        phase_valid_q <= 1'b0;
                    end
                endcase
            end

            // A clear that coincides with an error keeps that error.
            if (bus.clr_err) begin
                err_cnt_q <= err_event ? ERR_W'(1) : '0;
            end else if (err_event && (err_cnt_q != ERR_MAX)) begin
                err_cnt_q <= err_cnt_q + ERR_W'(1);
            end
        end
    end

    assign bus.locked      = locked_q;
    assign bus.phase       = phase_q;
    assign bus.phase_valid = phase_valid_q;
    assign bus.err         = err_q;
    assign bus.err_cnt     = err_cnt_q;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_ring_pattern_decoder.sv
// tb_ring_pattern_decoder
//   Directed scenarios followed by randomized traffic, all checked against a
//   phase-level reference model. ERR_W is 2 so saturation is reachable.
module tb_ring_pattern_decoder;

    localparam int W    = 4;
    localparam int PW   = 2;
    localparam int LC   = 3;
    localparam int EW   = 2;
    localparam int EMAX = (1 << EW) - 1;
    localparam logic [W-1:0] SEED = 4'b1001;

    logic clk;
    logic rst;

    ring_pattern_decoder_if #(.WIDTH(W), .PHASE_W(PW), .ERR_W(EW)) bus ();

    ring_pattern_decoder #(
        .WIDTH(W), .SEED(SEED), .PHASE_W(PW), .LOCK_COUNT(LC), .ERR_W(EW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard counters
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // reference model: tracks modes by name and phases as integers
    int m_mode;   // 0 hunt, 1 confirm, 2 locked
    int m_phase;
    int m_match;
    int m_cnt;
    bit m_locked;
    bit m_pv;
    bit m_err;

    function automatic logic [W-1:0] pat_of(input int k);
        int v;
        v = int'(SEED);
        return W'(((v >> k) | (v << (W - k))) & ((1 << W) - 1));
    endfunction

    function automatic int phase_of(input logic [W-1:0] p);
        for (int k = 0; k < W; k++)
            if (pat_of(k) == p) return k;
        return -1;
    endfunction

    task automatic model_step(input bit v, input logic [W-1:0] p, input bit c, input bit r);
        int k;
        bit ev;
        if (r) begin
            m_mode = 0; m_phase = 0; m_match = 0; m_cnt = 0;
            m_locked = 0; m_pv = 0; m_err = 0;
            return;
        end
        ev = 0;
        if (v) begin
            k = phase_of(p);
            if (m_mode == 0) begin
                if (k >= 0) begin
                    m_mode = 1; m_phase = k; m_match = 1; m_pv = 1;
                end else m_pv = 0;
            end else if (m_mode == 1) begin
                if (k >= 0 && k == (m_phase + 1) % W) begin
                    m_phase = k; m_match++;
                    if (m_match == LC) begin m_locked = 1; m_mode = 2; end
                end else if (k >= 0) begin
                    m_phase = k; m_match = 1;
                end else begin
                    m_mode = 0; m_pv = 0; m_match = 0;
                end
            end else begin
                if (k >= 0 && k == (m_phase + 1) % W) m_phase = k;
                else begin
                    ev = 1; m_locked = 0;
                    if (k >= 0) begin
                        m_mode = 1; m_phase = k; m_match = 1; m_pv = 1;
                    end else begin
                        m_mode = 0; m_pv = 0; m_match = 0;
                    end
                end
            end
        end
        m_err = ev;
        if (c) m_cnt = ev ? 1 : 0;
        else if (ev && m_cnt < EMAX) m_cnt++;
    endtask

    // driver: apply inputs, clock once, compare every output to the model
    task automatic step(input bit v, input logic [W-1:0] p, input bit c, input bit r);
        bus.in_valid = v;
        bus.in_pat   = p;
        bus.clr_err  = c;
        rst          = r;
        @(posedge clk);
        model_step(v, p, c, r);
        #1;
        chk("locked",      32'(bus.locked),      32'(m_locked));
        chk("phase",       32'(bus.phase),       32'(m_phase));
        chk("phase_valid", 32'(bus.phase_valid), 32'(m_pv));
        chk("err",         32'(bus.err),         32'(m_err));
        chk("err_cnt",     32'(bus.err_cnt),     32'(m_cnt));
        chk("state",       32'(bus.state_dbg),   32'(m_mode));
    endtask

    task automatic send(input logic [W-1:0] p);
        step(1'b1, p, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, W'($urandom_range(0, (1 << W) - 1)), 1'b0, 1'b0);
    endtask

    task automatic lock_seq();
        send(4'b1001); send(4'b1100); send(4'b0110);
    endtask

    initial begin
        logic [W-1:0] p;
        int sel;
        bus.in_valid = 1'b0;
        bus.in_pat   = '0;
        bus.clr_err  = 1'b0;
        rst          = 1'b1;
        m_mode = 0; m_phase = 0; m_match = 0; m_cnt = 0;
        m_locked = 0; m_pv = 0; m_err = 0;

        // reset, then lock
        step(1'b1, 4'b1001, 1'b0, 1'b1);
        step(1'b0, 4'b0000, 1'b0, 1'b1);
        chk("rst_locked", 32'(bus.locked), 0);
        chk("rst_pv", 32'(bus.phase_valid), 0);
        chk("rst_state", 32'(bus.state_dbg), 0);
        lock_seq();
        chk("lock_locked", 32'(bus.locked), 1);
        chk("lock_phase", 32'(bus.phase), 2);
        chk("lock_cnt", 32'(bus.err_cnt), 0);

        // wrap with sparse valid
        send(4'b0011);
        chk("wrap_ph3", 32'(bus.phase), 3);
        repeat (3) idle();
        send(4'b1001);
        chk("wrap_ph0", 32'(bus.phase), 0);
        chk("wrap_locked", 32'(bus.locked), 1);

        // phase skip
        send(4'b1100);
        send(4'b0011);
        chk("skip_err", 32'(bus.err), 1);
        chk("skip_cnt", 32'(bus.err_cnt), 1);
        chk("skip_state", 32'(bus.state_dbg), 1);
        chk("skip_phase", 32'(bus.phase), 3);
        idle();
        chk("skip_err_1cyc", 32'(bus.err), 0);
        send(4'b1001);
        send(4'b1100);
        chk("relock", 32'(bus.locked), 1);
        chk("relock_ph", 32'(bus.phase), 1);

        // illegal pattern
        send(4'b0000);
        chk("ill_err", 32'(bus.err), 1);
        chk("ill_cnt", 32'(bus.err_cnt), 2);
        chk("ill_pv", 32'(bus.phase_valid), 0);
        send(4'b1111);
        send(4'b0101);
        chk("ill_hunt", 32'(bus.state_dbg), 0);

        // saturation and clear
        repeat (5) begin
            lock_seq();
            send(4'b0000);
        end
        chk("sat_cnt", 32'(bus.err_cnt), 3);
        lock_seq();
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        chk("clr_err_same", 32'(bus.err_cnt), 1);
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        chk("clr_alone", 32'(bus.err_cnt), 0);

        // mid-operation reset while confirming
        send(4'b1001);
        send(4'b1100);
        step(1'b1, 4'b0110, 1'b0, 1'b1);
        chk("mrst_locked", 32'(bus.locked), 0);
        chk("mrst_pv", 32'(bus.phase_valid), 0);
        chk("mrst_phase", 32'(bus.phase), 0);
        send(4'b1001);
        send(4'b1100);
        chk("mrst_not_yet", 32'(bus.locked), 0);
        send(4'b0110);
        chk("mrst_relock", 32'(bus.locked), 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 55)      p = pat_of((m_phase + 1) % W);
            else if (sel < 70) p = pat_of(int'($urandom_range(0, W - 1)));
            else begin
                do p = W'($urandom_range(0, (1 << W) - 1)); while (phase_of(p) >= 0);
            end
            step(($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0, p,
                 ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
